// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction-cache responder: frame layout and fill FSM states.
package cpu_types_pkg;

    localparam int ICACHE_SETS   = 16;
    localparam int ICACHE_ADDR_W = 32;
    localparam int ICACHE_WORD_W = 32;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W  = ICACHE_ADDR_W - 2 - ICACHE_IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Hits answer combinationally in IDLE; misses are filled from memory in FETCH.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int ADDR_W = ICACHE_ADDR_W,
    parameter int WORD_W = ICACHE_WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    icache_frame_t        frames_q [SETS];
    icache_state_t        state_q;
    logic [ADDR_W-1:0]    addr_q;

    logic [IDX_W-1:0]     idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [IDX_W-1:0]     fill_idx_s;
    logic [TAG_W-1:0]     fill_tag_s;
    logic                 hit_s;
    logic                 unused_s;

    assign idx_s      = imemaddr[2 +: IDX_W];
    assign tag_s      = imemaddr[ADDR_W-1 -: TAG_W];
    assign fill_idx_s = addr_q[2 +: IDX_W];
    assign fill_tag_s = addr_q[ADDR_W-1 -: TAG_W];
    assign unused_s   = ^imemaddr[1:0];

    // Hit compare is only meaningful while idle; FETCH never reports a hit.
    assign hit_s = (state_q == IDLE) && imemREN && frames_q[idx_s].valid
                   && (frames_q[idx_s].tag == tag_s);

    // Output decode from current state and frame lookup.
    always_comb begin
        ihit     = hit_s;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        if (hit_s) begin
            imemload = frames_q[idx_s].data;
        end else begin
            imemload = '0;
        end
        if (state_q == FETCH) begin
            iREN  = 1'b1;
            iaddr = addr_q;
        end else begin
            iREN  = 1'b0;
            iaddr = '0;
        end
    end

    // Fill FSM: latch the missing word address, then write the frame when memory answers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit_s) begin
                        addr_q  <= {imemaddr[ADDR_W-1:2], 2'b00};
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        frames_q[fill_idx_s] <= '{valid: 1'b1, tag: fill_tag_s, data: iload};
                        state_q              <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a word-address-level cache model.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    // Model: each set remembers which word address it holds and that word's data.
    bit          m_vld  [16];
    logic [29:0] m_word [16];
    logic [31:0] m_data [16];
    bit          m_busy;
    logic [29:0] m_miss_word;

    icache_responder dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int s;
        s = int'(a[5:2]);
        return !m_busy && imemREN && m_vld[s] && (m_word[s] == a[31:2]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) m_vld[s] = 1'b0;
        m_busy      = 1'b0;
        m_miss_word = 30'd0;
    endtask

    // Apply inputs, then at the falling edge compare all outputs with the model.
    task automatic drive(input logic ren, input logic [31:0] a, input logic w, input logic [31:0] d);
        bit h;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = d;
        @(negedge CLK);
        h = model_hit(a);
        chk("ihit", {31'd0, ihit}, {31'd0, h});
        chk("imemload", imemload, h ? m_data[int'(a[5:2])] : 32'd0);
        chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
        chk("iaddr", iaddr, m_busy ? {m_miss_word, 2'b00} : 32'd0);
    endtask

    // Advance one clock edge and move the model the same way.
    task automatic adv();
        bit h;
        h = model_hit(imemaddr);
        if (!nRST) begin
            model_reset();
        end else if (m_busy) begin
            if (!iwait) begin
                m_vld[int'(m_miss_word[3:0])]  = 1'b1;
                m_word[int'(m_miss_word[3:0])] = m_miss_word;
                m_data[int'(m_miss_word[3:0])] = iload;
                m_busy = 1'b0;
            end
        end else if (imemREN && !h) begin
            m_busy      = 1'b1;
            m_miss_word = imemaddr[31:2];
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] tags [4];
        tags[0] = 32'h0000_0000;
        tags[1] = 32'h0000_0040;
        tags[2] = 32'h1234_5680;
        tags[3] = 32'hFFFF_FFC0;

        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Reset state
        drive(1'b0, 32'h0, 1'b1, 32'h0);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        adv();
        nRST = 1'b1;

        // 1: cold miss with three wait cycles
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("t1_miss_ihit", {31'd0, ihit}, 32'd0);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
            chk("t1_iREN", {31'd0, iREN}, 32'd1);
            chk("t1_iaddr", iaddr, 32'h40);
            adv();
        end
        drive(1'b1, 32'h40, 1'b0, 32'h2001_000A);
        chk("t1_iREN_last", {31'd0, iREN}, 32'd1);
        chk("t1_ihit_during_fill", {31'd0, ihit}, 32'd0);
        adv();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("t1_ihit", {31'd0, ihit}, 32'd1);
        chk("t1_imemload", imemload, 32'h2001_000A);
        adv();

        // 2: warm hit on a byte offset within the same word
        drive(1'b1, 32'h42, 1'b1, 32'h0);
        chk("t2_ihit", {31'd0, ihit}, 32'd1);
        chk("t2_iREN", {31'd0, iREN}, 32'd0);
        chk("t2_imemload", imemload, 32'h2001_000A);
        adv();

        // 3: same-index conflict evicts 0x40; fast fill (iwait=0 at once)
        drive(1'b1, 32'h80, 1'b0, 32'h0000_0080);
        adv();
        drive(1'b1, 32'h80, 1'b0, 32'h0000_0080);
        chk("t3_iaddr80", iaddr, 32'h80);
        adv();
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        chk("t3_ihit80", {31'd0, ihit}, 32'd1);
        chk("t3_load80", imemload, 32'h0000_0080);
        adv();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("t3_remiss", {31'd0, ihit}, 32'd0);
        adv();
        drive(1'b1, 32'h40, 1'b0, 32'h1111_0040);
        chk("t3_iREN", {31'd0, iREN}, 32'd1);
        chk("t3_iaddr", iaddr, 32'h40);
        adv();

        // 5: reset during FETCH abandons the fill
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        adv();
        nRST = 1'b0;
        drive(1'b1, 32'h80, 1'b0, 32'h5555_5555);
        chk("t5_iREN_before", {31'd0, iREN}, 32'd1);
        adv();
        nRST = 1'b1;
        drive(1'b0, 32'h80, 1'b1, 32'h0);
        chk("t5_iREN_after", {31'd0, iREN}, 32'd0);
        chk("t5_ihit_after", {31'd0, ihit}, 32'd0);
        adv();

        // 4: address change mid-fill (also shows 0x40 misses after reset)
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("t4_miss40", {31'd0, ihit}, 32'd0);
        adv();
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        chk("t4_iaddr40a", iaddr, 32'h40);
        adv();
        drive(1'b1, 32'h44, 1'b0, 32'hABCD_0040);
        chk("t4_iaddr40b", iaddr, 32'h40);
        adv();
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        chk("t4_miss44", {31'd0, ihit}, 32'd0);
        adv();
        drive(1'b1, 32'h44, 1'b0, 32'hABCD_0044);
        chk("t4_iaddr44", iaddr, 32'h44);
        adv();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("t4_hit40", {31'd0, ihit}, 32'd1);
        chk("t4_load40", imemload, 32'hABCD_0040);
        adv();

        // 6: idle stability
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
            chk("t6_iREN", {31'd0, iREN}, 32'd0);
            adv();
        end
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        chk("t6_load44", imemload, 32'hABCD_0044);
        adv();

        // Randomized traffic over a small tag pool so hits and conflicts are frequent
        for (int i = 0; i < 3000; i++) begin
            nRST = ($urandom_range(0, 199) != 0);
            a = tags[$urandom_range(0, 3)] | {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (a[31:6] == 26'h0000001) a[31:6] = 26'h0000001;
            drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 1) == 1), $urandom);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
